// File: rtl/oam_dma_arbiter_pkg.sv
// oam_dma_arbiter_pkg: shared bus widths, register addresses and FSM encoding for the OAM DMA arbiter.
package oam_dma_arbiter_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int REG_WIDTH = 8;
    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    typedef enum logic [2:0] {
        DMA_ST_IDLE  = 3'd0,
        DMA_ST_HALT  = 3'd1,
        DMA_ST_ALIGN = 3'd2,
        DMA_ST_READ  = 3'd3,
        DMA_ST_WRITE = 3'd4
    } dma_state_e;
endpackage

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: CPU bus pass-through with a CPU-stalling sprite DMA into OAM.
// Define DMA_PARITY_ALIGN_EN to add the odd-cycle ALIGN stall before the first read.
module oam_dma_arbiter #(
    parameter int ADDR_WIDTH = oam_dma_arbiter_pkg::ADDR_WIDTH,
    parameter int REG_WIDTH = oam_dma_arbiter_pkg::REG_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = ADDR_WIDTH'(oam_dma_arbiter_pkg::DMA_REG_ADDR),
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = ADDR_WIDTH'(oam_dma_arbiter_pkg::OAM_DATA_ADDR),
    parameter int XFER_LEN = 256
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0]  cpu_data_out,
    input  logic                  cpu_we,
    input  logic [REG_WIDTH-1:0]  bus_data_in,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [REG_WIDTH-1:0]  bus_data_out,
    output logic                  bus_we,
    output logic                  cpu_rdy,
    output logic                  dma_active
);
    import oam_dma_arbiter_pkg::*;

    localparam int IDX_W = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

    dma_state_e           state_q, state_d;
    logic [7:0]           page_q, page_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [REG_WIDTH-1:0] latch_q, latch_d;
    logic                 halt_align;

`ifdef DMA_PARITY_ALIGN_EN
    logic parity_q;

    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) parity_q <= 1'b0;
        else          parity_q <= !parity_q;
    end

    // Parity has flipped once since the trigger edge, so an odd trigger shows as even in HALT.
    assign halt_align = !parity_q;
`else
    assign halt_align = 1'b0;
`endif

    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DMA_ST_IDLE;
            page_q  <= '0;
            idx_q   <= '0;
            latch_q <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            latch_q <= latch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        latch_d = latch_q;
        case (state_q)
            DMA_ST_IDLE: begin
                if (cpu_we && cpu_addr == DMA_REG_ADDR) begin
                    page_d  = 8'(cpu_data_out);
                    idx_d   = '0;
                    state_d = DMA_ST_HALT;
                end
            end
            DMA_ST_HALT:  state_d = halt_align ? DMA_ST_ALIGN : DMA_ST_READ;
            DMA_ST_ALIGN: state_d = DMA_ST_READ;
            DMA_ST_READ: begin
                latch_d = bus_data_in;
                state_d = DMA_ST_WRITE;
            end
            DMA_ST_WRITE: begin
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == IDX_LAST) ? DMA_ST_IDLE : DMA_ST_READ;
            end
            default: state_d = DMA_ST_IDLE;
        endcase
    end

    always_comb begin
        bus_addr     = '0;
        bus_data_out = '0;
        bus_we       = 1'b0;
        case (state_q)
            DMA_ST_IDLE: begin
                bus_addr     = cpu_addr;
                bus_data_out = cpu_data_out;
                bus_we       = cpu_we;
            end
            DMA_ST_READ: bus_addr = ADDR_WIDTH'({page_q, 8'(idx_q)});
            DMA_ST_WRITE: begin
                bus_addr     = OAM_DATA_ADDR;
                bus_data_out = latch_q;
                bus_we       = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_rdy    = (state_q == DMA_ST_IDLE);
    assign dma_active = !cpu_rdy;
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: randomized scoreboard bench; expected bus cycles are queued at each trigger and checked by a monitor.
module tb_oam_dma_arbiter;
    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] OAM  = 16'h2004;

    logic        phi1 = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr, bus_addr;
    logic [7:0]  cpu_data_out, bus_data_in, bus_data_out;
    logic        cpu_we, bus_we, cpu_rdy, dma_active;

    oam_dma_arbiter dut (
        .phi1(phi1), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out), .cpu_we(cpu_we),
        .bus_data_in(bus_data_in), .bus_addr(bus_addr), .bus_data_out(bus_data_out),
        .bus_we(bus_we), .cpu_rdy(cpu_rdy), .dma_active(dma_active)
    );

    always #5 phi1 = ~phi1;

    logic [7:0] mem [0:65535];
    assign bus_data_in = mem[bus_addr];
    always @(posedge phi1) if (bus_we) mem[bus_addr] = bus_data_out;

    int cyc;
    always @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
    } bus_t;

    bus_t exp_q[$];
    int   stall_q[$];
    int   stall_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bus_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge phi1) begin
        if (reset_n) begin
            if (!cpu_rdy) begin
                stall_cnt++;
                check("dma_active in stall", 32'(dma_active), 32'd1);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra stall cycle: got bus_addr %h with no cycle expected", bus_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dma bus_addr", 32'(bus_addr), 32'(mon_e.addr));
                    check("dma bus_we", 32'(bus_we), 32'(mon_e.we));
                    if (mon_e.we) check("dma bus_data_out", 32'(bus_data_out), 32'(mon_e.data));
                end
            end else begin
                if (stall_cnt > 0) begin
                    check("stall length", 32'(stall_cnt), 32'(stall_q.size() > 0 ? stall_q.pop_front() : 0));
                    stall_cnt = 0;
                end
                check("pass-through", {6'd0, bus_addr, bus_data_out, bus_we, dma_active},
                      {6'd0, cpu_addr, cpu_data_out, cpu_we, 1'b0});
            end
        end
    end

    task automatic step();
        @(posedge phi1);
        #1;
    endtask

    // CPU writes stay in the upper half so they never hit the trigger or preloaded low pages.
    task automatic set_idle();
        cpu_addr     = 16'($urandom);
        cpu_data_out = 8'($urandom);
        cpu_we       = 1'($urandom);
        if (cpu_we) cpu_addr[15] = 1'b1;
    endtask

    task automatic trigger(input logic [7:0] page, input int parity);
        logic al;
        step();
        for (int g = 0; g < 4 && parity >= 0 && (cyc % 2) != parity; g++) begin
            set_idle();
            step();
        end
`ifdef DMA_PARITY_ALIGN_EN
        al = cyc[0];
`else
        al = 1'b0;
`endif
        cpu_addr     = TRIG;
        cpu_data_out = page;
        cpu_we       = 1'b1;
        exp_q.push_back('{addr: 16'h0000, we: 1'b0, data: 8'h00});
        if (al) exp_q.push_back('{addr: 16'h0000, we: 1'b0, data: 8'h00});
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{addr: {page, 8'(i)}, we: 1'b0, data: 8'h00});
            exp_q.push_back('{addr: OAM, we: 1'b1, data: mem[{page, 8'(i)}]});
        end
        stall_q.push_back(al ? 514 : 513);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !cpu_rdy) && n < 700) begin
            step();
            set_idle();
            n++;
        end
        if (n >= 700) begin
            vectors++;
            miscompares++;
            $display("FAIL transfer timeout: got %0d cycles still pending, required completion within 700", exp_q.size());
        end
    endtask

    function automatic logic [7:0] rand_page();
        logic [7:0] p;
        p = 8'($urandom);
        if (p == 8'h20 || p == 8'h40) p = 8'h21;
        return p;
    endfunction

    initial begin
        cpu_addr = 16'h0200; cpu_data_out = 8'h00; cpu_we = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        #2;
        check("reset bus_addr", 32'(bus_addr), 32'h0200);
        check("reset bus_we", 32'(bus_we), 32'd0);
        check("reset cpu_rdy", 32'(cpu_rdy), 32'd1);
        check("reset dma_active", 32'(dma_active), 32'd0);
        @(posedge phi1); #3 reset_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            step();
            set_idle();
        end
        step();
        cpu_addr = TRIG; cpu_we = 1'b0; cpu_data_out = 8'h09;
        step();
        check("no trigger without we", 32'(cpu_rdy), 32'd1);
        set_idle();

        trigger(8'h02, 0);
        step();
        cpu_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            cpu_addr = TRIG; cpu_data_out = 8'h07; cpu_we = 1'b1;
        end
        step();
        cpu_we = 1'b0;
        wait_done();

        trigger(rand_page(), 1);
        wait_done();

        trigger(8'hFF, -1);
        wait_done();

        trigger(8'h03, -1);
        for (int n = 0; n < 700 && exp_q.size() > 2 * (256 - 100); n++) begin
            step();
            cpu_we = 1'b0;
        end
        @(posedge phi1); #3 reset_n = 1'b0;
        #1;
        check("abort cpu_rdy", 32'(cpu_rdy), 32'd1);
        check("abort dma_active", 32'(dma_active), 32'd0);
        check("abort pass-through", {15'd0, bus_addr, bus_we}, {15'd0, cpu_addr, cpu_we});
        exp_q.delete();
        stall_q.delete();
        stall_cnt = 0;
        repeat (2) @(posedge phi1);
        #3 reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            set_idle();
        end

        for (int t = 0; t < 3; t++) begin
            trigger(rand_page(), -1);
            wait_done();
        end

        for (int k = 0; k < 5; k++) begin
            step();
            set_idle();
        end
        step();
        cpu_we = 1'b0;
        @(negedge phi1); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Owns the shared CPU memory bus.
- Normally passes fetcher/CPU address, data and write-enable straight through to memory.
- A CPU write of page number P to DMA_REG_ADDR starts a sprite DMA. The block stalls the CPU via cpu_rdy and copies XFER_LEN bytes from P:00..P:FF to OAM_DATA_ADDR, one byte per read/write cycle pair.
- Sits between fetcher/execute and the memory map decoder.

Parameters:
- ADDR_WIDTH, 16, bus address width
- REG_WIDTH, 8, data width
- DMA_REG_ADDR, 16'h4014, trigger register address
- OAM_DATA_ADDR, 16'h2004, DMA write target
- XFER_LEN, 256, bytes per transfer (power of 2, at most 256)

Ports:
- phi1  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- cpu_addr  in  ADDR_WIDTH  CPU-requested address
- cpu_data_out  in  REG_WIDTH  CPU write data
- cpu_we  in  1  CPU write strobe
- bus_data_in  in  REG_WIDTH  memory read data
- bus_addr  out  ADDR_WIDTH  address to memory
- bus_data_out  out  REG_WIDTH  write data to memory
- bus_we  out  1  write strobe to memory
- cpu_rdy  out  1  1 = CPU may advance; 0 = CPU/fetcher must hold
- dma_active  out  1  transfer in progress

Behaviour:
- Interface: one clock, phi1. reset_n is asynchronous and active-low.
- State register: IDLE, HALT, ALIGN, READ, WRITE.
- Internal registers:
  - page[7:0]
  - idx (log2 XFER_LEN bits)
  - byte_latch[REG_WIDTH]
  - parity (toggles every phi1 while out of reset)
- Reset (async): state=IDLE, page=0, idx=0, byte_latch=0, parity=0. Outputs therefore reset to cpu_rdy=1, dma_active=0, and bus = CPU pass-through.
- Outputs are combinational from the state register:
  - IDLE: bus_addr=cpu_addr, bus_data_out=cpu_data_out, bus_we=cpu_we.
  - HALT/ALIGN: bus_addr=0, bus_data_out=0, bus_we=0.
  - READ: bus_addr={page, idx}, bus_we=0.
  - WRITE: bus_addr=OAM_DATA_ADDR, bus_data_out=byte_latch, bus_we=1.
  - cpu_rdy = (state==IDLE); dma_active = !cpu_rdy.
- IDLE: trigger when cpu_we && cpu_addr==DMA_REG_ADDR. The write itself also reaches memory (pass-through). On that edge: page<=cpu_data_out, idx<=0, state<=HALT.
- HALT (1 cycle): go to ALIGN if alignment is required (see Optional Feature), else to READ.
- ALIGN (1 cycle): go to READ.
- READ: byte_latch<=bus_data_in; go to WRITE.
- WRITE:
  - if idx==XFER_LEN-1: idx<=0, state<=IDLE.
  - else: idx<=idx+1 (modulo), state<=READ.
- Latency: stall spans 1 + (ALIGN?1:0) + 2*XFER_LEN cycles, i.e. 513 or 514 at default. cpu_rdy returns to 1 in the cycle after the final WRITE.
- Boundaries:
  - A trigger write while not IDLE is ignored: no restart, page unchanged.
  - Page 0xFF is legal; the read address never carries into the high byte (idx wraps).
  - A cpu_addr match without cpu_we is not a trigger.
  - Reset mid-transfer aborts immediately. Memory keeps partial writes, and the bus returns to pass-through while reset_n is low.

Optional Feature:
- Macro: DMA_PARITY_ALIGN_EN
- Defined: parity is sampled at the trigger edge. If the trigger write occurs on an odd cycle (parity==1), HALT goes to ALIGN, giving 514 stall cycles; otherwise 513.
- Undefined: the parity register and ALIGN path are removed, HALT always goes to READ, and stall is always 513.

Decomposition:
- Shared package/defines:
  - state encodings (DMA_ST_IDLE..DMA_ST_WRITE, 3 bits)
  - DMA_REG_ADDR, OAM_DATA_ADDR
  - existing REG_WIDTH and ADDR_WIDTH
- No sub-module. The FSM, counter and bus mux are single-module scope.

Test Plan:
- Reset then idle: cpu_addr=0x0200, cpu_we=0 -> bus_addr=0x0200, bus_we=0, cpu_rdy=1. Assert reset_n=0 asynchronously mid-cycle -> outputs at reset values without waiting for phi1.
- Trigger write 0x02 to 0x4014 on an even cycle, memory preloaded with 0x0200+i = i^0x5A -> cpu_rdy=0 for exactly 513 cycles. 256 writes to 0x2004 with data i^0x5A in order i=0..255. Then cpu_rdy=1 and pass-through resumes.
- With DMA_PARITY_ALIGN_EN, trigger on an odd cycle -> exactly 514 stall cycles and one extra idle-bus cycle before the first READ of 0x0200. Without the macro -> 513.
- Page 0xFF transfer -> last read address 0xFFFF, no access to 0x0000+. idx wraps to 0 and the FSM returns to IDLE.
- Second trigger (cpu_we=1, cpu_addr=0x4014, data 0x07) asserted during the transfer -> ignored; page stays 0x02 and the cycle count is unchanged.
- Assert reset_n=0 at byte 100 of a transfer -> cpu_rdy=1 and dma_active=0 immediately. After release, normal pass-through; a fresh trigger restarts at idx 0.
